// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared states and requester indices for adder_scheduler
// Contents: state_t (IDLE/RUN/DONE encodings), REQ0/REQ1 requester index constants.
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/adder_scheduler_adder.sv
// rtl/adder_scheduler_adder.sv - SIZE-bit ripple-carry adder built from a full-adder chain
// Ports:
//   a, b  in  SIZE  addends
//   cin   in  1     carry into bit 0
//   sum   out SIZE  a + b + cin modulo 2^SIZE
//   cout  out 1     carry out of bit SIZE-1
module adder_scheduler_adder #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic            cout
);

  logic [SIZE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SIZE; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SIZE];

endmodule

// File: rtl/adder_scheduler.sv
// rtl/adder_scheduler.sv - two-requester scheduler sharing one SIZE-bit adder over CHUNKS slices
// Config macro: ADDER_SCHED_FIXED_PRIO_EN (defined: requester 0 always wins a tie;
//   undefined: round-robin between the two requesters).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   vld0/vld1, rdy0/rdy1  per-requester request / accept handshake
//   a0,b0,cin0 / a1,b1,cin1  operands, sampled only on handshake
//   done0/done1           one-cycle result-valid pulse
//   sum0,cout0 / sum1,cout1  last completed result per requester
module adder_scheduler
  import adder_sched_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int CHUNKS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vld0,
  input  logic                   vld1,
  output logic                   rdy0,
  output logic                   rdy1,
  input  logic [SIZE*CHUNKS-1:0] a0,
  input  logic [SIZE*CHUNKS-1:0] b0,
  input  logic [SIZE*CHUNKS-1:0] a1,
  input  logic [SIZE*CHUNKS-1:0] b1,
  input  logic                   cin0,
  input  logic                   cin1,
  output logic                   done0,
  output logic                   done1,
  output logic [SIZE*CHUNKS-1:0] sum0,
  output logic [SIZE*CHUNKS-1:0] sum1,
  output logic                   cout0,
  output logic                   cout1
);

  localparam int W  = SIZE * CHUNKS;
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  state_t          state;
  logic            owner;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic [W-1:0]    work;
  logic [W-1:0]    opa;
  logic [W-1:0]    opb;

  logic            gnt;
  logic            hs;
  logic [SIZE-1:0] slice_a;
  logic [SIZE-1:0] slice_b;
  logic [SIZE-1:0] slice_sum;
  logic            slice_cout;
  logic [W-1:0]    full;
  logic            last_slice;

`ifndef ADDER_SCHED_FIXED_PRIO_EN
  logic            last;
`endif

  // Arbiter: a lone requester always wins; on a tie the pointer decides.
  always_comb begin
    gnt = REQ0;
    if (vld0 && vld1) begin
`ifdef ADDER_SCHED_FIXED_PRIO_EN
      gnt = REQ0;
`else
      gnt = (last == REQ0) ? REQ1 : REQ0;
`endif
    end else if (vld1) begin
      gnt = REQ1;
    end
  end

  assign rdy0 = (state == IDLE) && vld0 && (gnt == REQ0);
  assign rdy1 = (state == IDLE) && vld1 && (gnt == REQ1);
  assign hs   = rdy0 | rdy1;

  assign slice_a    = opa[int'(cnt)*SIZE +: SIZE];
  assign slice_b    = opb[int'(cnt)*SIZE +: SIZE];
  assign last_slice = (cnt == CW'(CHUNKS - 1));

  // carry holds the latched cin on slice 0, then each slice's carry-out.
  adder_scheduler_adder #(
    .SIZE (SIZE)
  ) u_adder (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Work register with the current slice merged in; on the last slice this
  // is the complete W-bit result.
  always_comb begin
    full = work;
    full[int'(cnt)*SIZE +: SIZE] = slice_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= REQ0;
      cnt   <= '0;
      carry <= 1'b0;
      work  <= '0;
      opa   <= '0;
      opb   <= '0;
      sum0  <= '0;
      sum1  <= '0;
      cout0 <= 1'b0;
      cout1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
`ifndef ADDER_SCHED_FIXED_PRIO_EN
      last  <= REQ1;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            owner <= gnt;
            opa   <= (gnt == REQ1) ? a1 : a0;
            opb   <= (gnt == REQ1) ? b1 : b0;
            carry <= (gnt == REQ1) ? cin1 : cin0;
            cnt   <= '0;
            work  <= '0;
            state <= RUN;
`ifndef ADDER_SCHED_FIXED_PRIO_EN
            last  <= gnt;
`endif
          end
        end
        RUN: begin
          work  <= full;
          carry <= slice_cout;
          if (last_slice) begin
            cnt   <= '0;
            state <= DONE;
            if (owner == REQ0) begin
              sum0  <= full;
              cout0 <= slice_cout;
              done0 <= 1'b1;
            end else begin
              sum1  <= full;
              cout1 <= slice_cout;
              done1 <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_scheduler.sv
// tb/tb_adder_scheduler.sv - self-checking bench for adder_scheduler (SIZE=8, CHUNKS=4)
module tb_adder_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld0 = 1'b0, vld1 = 1'b0;
  logic        rdy0, rdy1;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        cin0 = 1'b0, cin1 = 1'b0;
  logic        done0, done1;
  logic [31:0] sum0, sum1;
  logic        cout0, cout1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference state: last result per requester and last-served requester.
  logic [31:0] m_sum [2];
  logic        m_cout [2];
  int          m_last;

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] esum;
    logic        ecout;
  } vec_t;

  vec_t vecs [7];

  adder_scheduler #(.SIZE(8), .CHUNKS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vld0  (vld0),
    .vld1  (vld1),
    .rdy0  (rdy0),
    .rdy1  (rdy1),
    .a0    (a0),
    .b0    (b0),
    .a1    (a1),
    .b1    (b1),
    .cin0  (cin0),
    .cin1  (cin1),
    .done0 (done0),
    .done1 (done1),
    .sum0  (sum0),
    .sum1  (sum1),
    .cout0 (cout0),
    .cout1 (cout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy_of(input int k);
    return (k == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic done_of(input int k);
    return (k == 0) ? done0 : done1;
  endfunction

  function automatic logic [31:0] sum_of(input int k);
    return (k == 0) ? sum0 : sum1;
  endfunction

  function automatic logic cout_of(input int k);
    return (k == 0) ? cout0 : cout1;
  endfunction

  task automatic drive(input int k, input logic v, input logic [31:0] a, input logic [31:0] b, input logic c);
    if (k == 0) begin vld0 = v; a0 = a; b0 = b; cin0 = c; end
    else        begin vld1 = v; a1 = a; b1 = b; cin1 = c; end
  endtask

  task automatic model_reset();
    m_sum[0] = '0; m_sum[1] = '0;
    m_cout[0] = 1'b0; m_cout[1] = 1'b0;
    m_last = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vld0 = 1'b0;
    vld1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Waits for done_k after a handshake seen at cycle t0; returns the cycle it was seen.
  task automatic wait_done(input int k, output int dcyc, output bit got);
    got = 0;
    dcyc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done_of(k)) begin
        got = 1;
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [31:0] esum, input logic ecout);
    int  t0, dcyc, waited;
    bit  got;
    @(negedge clk);
    drive(k, 1'b1, a, b, c);
    got = 0;
    waited = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (rdy_of(k)) begin got = 1; break; end
      waited++;
      @(negedge clk);
    end
    chk("grant_seen", 64'(got), 64'(1));
    if (!got) begin
      drive(k, 1'b0, a, b, c);
      return;
    end
    chk("grant_wait", 64'(waited), 64'(0));
    chk("rdy_other_low", 64'(rdy_of(1 - k)), 64'(0));
    t0 = cyc;
    @(posedge clk);
    #1;
    // Operands change after the handshake; they must not be used.
    drive(k, 1'b0, $urandom, $urandom, 1'($urandom));
    wait_done(k, dcyc, got);
    chk("done_seen", 64'(got), 64'(1));
    if (got) begin
      chk("latency", 64'(dcyc - t0), 64'(5));
      chk("sum", 64'(sum_of(k)), 64'(esum));
      chk("cout", 64'(cout_of(k)), 64'(ecout));
      chk("other_sum_kept", 64'(sum_of(1 - k)), 64'(m_sum[1 - k]));
      chk("other_cout_kept", 64'(cout_of(1 - k)), 64'(m_cout[1 - k]));
      chk("other_done_low", 64'(done_of(1 - k)), 64'(0));
      @(negedge clk);
      chk("done_one_cycle", 64'(done_of(k)), 64'(0));
    end
    m_sum[k] = esum;
    m_cout[k] = ecout;
    m_last = k;
  endtask

  initial begin
    int          t0, dcyc, seen, g, exp_g;
    bit          got;
    logic [32:0] full;
    logic [31:0] ra, rb;
    logic        rc;
    int          rk;

    vecs[0] = '{0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
    vecs[1] = '{1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vecs[2] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[3] = '{1, 32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0};
    vecs[4] = '{0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[5] = '{1, 32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};
    vecs[6] = '{0, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};

    // Reset state with no requests.
    do_reset();
    #1;
    chk("rst_rdy0", 64'(rdy0), 64'(0));
    chk("rst_rdy1", 64'(rdy1), 64'(0));
    chk("rst_done", 64'({done0, done1}), 64'(0));
    chk("rst_sum0", 64'(sum0), 64'(0));
    chk("rst_sum1", 64'(sum1), 64'(0));
    chk("rst_cout", 64'({cout0, cout1}), 64'(0));

    // Directed vectors.
    for (int i = 0; i < 7; i++)
      run_op(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].esum, vecs[i].ecout);

    // Requester 1 arrives while requester 0 is running.
    @(negedge clk);
    drive(0, 1'b1, 32'h11111111, 32'h22222222, 1'b0);
    #1;
    chk("seq35_rdy0", 64'(rdy0), 64'(1));
    t0 = cyc;
    @(posedge clk);
    #1;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) drive(1, 1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1);
      #1;
      chk("seq35_rdy1_blocked", 64'(rdy1), 64'(0));
      if (n == 5) chk("seq35_done0", 64'(done0), 64'(1));
    end
    chk("seq35_sum0", 64'(sum0), 64'(32'h33333333));
    m_sum[0] = 32'h33333333;
    m_cout[0] = 1'b0;
    @(negedge clk);
    #1;
    chk("seq35_rdy1_t6", 64'(rdy1), 64'(1));
    chk("seq35_t6_cycle", 64'(cyc - t0), 64'(6));
    @(posedge clk);
    #1;
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
    wait_done(1, dcyc, got);
    chk("seq35_done1_seen", 64'(got), 64'(1));
    chk("seq35_done1_t11", 64'(dcyc - t0), 64'(11));
    chk("seq35_sum1", 64'(sum1), 64'(32'h00000000));
    chk("seq35_cout1", 64'(cout1), 64'(1));
    chk("seq35_sum0_kept", 64'(sum0), 64'(32'h33333333));

    // Reset while slice 2 is being computed.
    @(negedge clk);
    drive(0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    #1;
    chk("seq34_rdy0", 64'(rdy0), 64'(1));
    t0 = cyc;
    @(posedge clk);
    #1;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n == 0) rst_n = 1'b1;
      if (done0 || done1) seen = 1;
    end
    model_reset();
    chk("seq34_no_done", 64'(seen), 64'(0));
    chk("seq34_sum0", 64'(sum0), 64'(0));
    chk("seq34_sum1", 64'(sum1), 64'(0));
    chk("seq34_cout", 64'({cout0, cout1}), 64'(0));
    run_op(0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0);

    // Both requesters held valid: grant order.
    do_reset();
    @(negedge clk);
    drive(0, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1);
    drive(1, 1'b1, 32'hDEADBEEF, 32'h21524111, 1'b0);
    for (int op = 0; op < 4; op++) begin
      got = 0;
      g = -1;
      for (int n = 0; n < 20; n++) begin
        #1;
        if (rdy0 || rdy1) begin
          got = 1;
          chk("arb_onehot", 64'(rdy0 & rdy1), 64'(0));
          g = rdy1 ? 1 : 0;
          break;
        end
        @(negedge clk);
      end
      chk("arb_grant_seen", 64'(got), 64'(1));
      if (!got) break;
`ifdef ADDER_SCHED_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = (m_last == 0) ? 1 : 0;
`endif
      chk("arb_order", 64'(g), 64'(exp_g));
      wait_done(g, dcyc, got);
      chk("arb_done_seen", 64'(got), 64'(1));
      full = (g == 0) ? (33'h0A5A5A5A5 + 33'h05A5A5A5A + 33'd1)
                      : (33'h0DEADBEEF + 33'h021524111);
      chk("arb_sum", 64'(sum_of(g)), 64'(full[31:0]));
      chk("arb_cout", 64'(cout_of(g)), 64'(full[32]));
      m_sum[g] = full[31:0];
      m_cout[g] = full[32];
      m_last = g;
      @(negedge clk);
    end
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (8) @(negedge clk);

    // Random single-requester operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      rk = int'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i % 4 == 0) ? ~ra : $urandom;
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      run_op(rk, ra, rb, rc, full[31:0], full[32]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_scheduler.md
ADDER_SCHEDULER -- requirements
Module: adder_scheduler

Interface
REQ-001 SHALL have parameter SIZE, default 8: width of the shared ripple adder slice.
REQ-002 SHALL have parameter CHUNKS, default 4, legal 2..16: slices per operand; operand width W = SIZE*CHUNKS.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 vld0, vld1  in  1  requester k has an operation pending.
REQ-007 rdy0, rdy1  out  1  requester k is accepted this cycle when vldk=1.
REQ-008 a0, b0, a1, b1  in  W  operands of requester k, sampled at handshake.
REQ-009 cin0, cin1  in  1  carry-in of requester k, sampled at handshake.
REQ-010 done0, done1  out  1  one-cycle pulse: result of requester k is valid.
REQ-011 sum0, sum1  out  W  result of requester k's last completed operation.
REQ-012 cout0, cout1  out  1  carry-out of requester k's last completed operation.

Function
REQ-013 SHALL be an FSM with states IDLE, RUN, DONE.
REQ-014 In IDLE, the arbiter SHALL select one valid requester; rdyk=1 only in IDLE for the selected k; rdy0=rdy1=0 when neither is valid.
REQ-015 Handshake (vldk & rdyk) SHALL latch ak, bk, cink, record owner k, clear slice counter, and go to RUN.
REQ-016 In RUN, slice counter i (0..CHUNKS-1) SHALL add operand slice i plus the carry register through one SIZE-bit adder, store result slice i and the carry-out into the carry register; i=0 uses latched cin.
REQ-017 After slice CHUNKS-1, SHALL go to DONE; on that edge sum/cout of the owner load the full W-bit result and final carry.
REQ-018 In DONE, doneowner=1 for exactly one cycle, then IDLE.
REQ-019 Latency: handshake in cycle T gives done at T+CHUNKS+1; next handshake at earliest T+CHUNKS+2.
REQ-020 sumk/coutk of the non-owner SHALL never change; owner's only on the DONE-entry edge.
REQ-021 Arbitration SHALL be round-robin: if both valid, grant the requester not served last; single valid requester always wins.
REQ-022 vldk deasserted before handshake SHALL cancel nothing and latch nothing; inputs are ignored outside handshake.
REQ-023 Arithmetic SHALL be modulo 2^W with cout the true carry out of bit W-1.

Reset
REQ-024 rst_n=0 at any edge SHALL force IDLE, clear counter, carry register and work register, set last-served to requester 1, and zero sum0, sum1, cout0, cout1, done0, done1.
REQ-025 Reset during RUN or DONE SHALL discard the operation with no done pulse.

Configuration
REQ-026 Macro ADDER_SCHED_FIXED_PRIO_EN defined: requester 0 SHALL always win when both valid; last-served pointer removed.
REQ-027 Macro undefined: round-robin per REQ-021.

Structure
REQ-028 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and requester index constants SHALL live in shared package adder_sched_pkg.
REQ-029 SHALL instantiate exactly one sub-module, the team's SIZE-bit ripple-carry Adder (FA chain), time-shared across slices and requesters.

Verification (SIZE=8, CHUNKS=4)
REQ-030 Reset held 2 cycles, no vld -> all outputs 0, rdy0=rdy1=0.
REQ-031 vld0, a0=0x000000FF, b0=0x00000001, cin0=0, handshake T -> done0 at T+5, sum0=0x00000100, cout0=0; sum1 unchanged.
REQ-032 vld1, a1=0xFFFFFFFF, b1=0, cin1=1 -> sum1=0x00000000, cout1=1 (carry ripples all four slices).
REQ-033 vld0=vld1=1 held 4 ops -> grant order 0,1,0,1; with ADDER_SCHED_FIXED_PRIO_EN -> 0,0,0,0.
REQ-034 rst_n=0 in RUN slice 2 -> no done pulse, sums zero, IDLE on release, next request completes normally.
REQ-035 vld1 raised while requester 0 in RUN -> rdy1=0 until IDLE, accepted at T+6, done1 at T+11.
